// File: rtl/seq_div_if.sv
// seq_div_if: operand/result handshake bundle for the iterative divider.
//   in_valid / in_ready       operand handshake (master -> slave)
//   dividend_i, divisor_i     unsigned operands, N bits
//   out_valid / out_ready     result handshake (slave -> master)
//   quot_o, rem_o             quotient and remainder, N bits
//   dbz_o                     divide-by-zero flag for the current result
interface seq_div_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend_i;
  logic [N-1:0] divisor_i;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quot_o;
  logic [N-1:0] rem_o;
  logic         dbz_o;

  modport master (
    output in_valid, dividend_i, divisor_i, out_ready,
    input  in_ready, out_valid, quot_o, rem_o, dbz_o
  );

  modport slave (
    input  in_valid, dividend_i, divisor_i, out_ready,
    output in_ready, out_valid, quot_o, rem_o, dbz_o
  );
endinterface

// File: rtl/seq_div.sv
// seq_div: iterative unsigned restoring divider, one quotient bit per clock.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards any operation in flight
//   bus    seq_div_if.slave: operands in (valid/ready), quotient, remainder
//          and divide-by-zero flag out (valid/ready)
// A divisor of zero completes in one cycle with quotient all ones and the
// dividend as remainder. Otherwise the result appears N cycles after accept.
module seq_div #(
  parameter int N = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_div_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [N-1:0]  q_sh;
  logic [N-1:0]  d_reg;
  // The restored partial remainder is always below the divisor, so only the
  // trial value T inside div_step needs the extra (N+1)th bit.
  logic [N-1:0]  r_reg;
  logic [N-1:0]  quot_q;
  logic [N-1:0]  rem_q;
  logic          dbz_q;
  logic [N:0]    step;

  // One restoring step: returns {quotient bit, new partial remainder}.
  // Compare and subtract are N+1 bits wide so a remainder at or above
  // 2^(N-1) shifted left cannot overflow.
  function automatic logic [N:0] div_step(input logic [N-1:0] r,
                                          input logic         q_msb,
                                          input logic [N-1:0] d);
    logic [N:0] t;
    t = {r, q_msb};
    if (t >= {1'b0, d}) begin
      div_step = {1'b1, N'(t - {1'b0, d})};
    end else begin
      div_step = {1'b0, t[N-1:0]};
    end
  endfunction

  assign step = div_step(r_reg, q_sh[N-1], d_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      q_sh   <= '0;
      d_reg  <= '0;
      r_reg  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            q_sh  <= bus.dividend_i;
            d_reg <= bus.divisor_i;
            r_reg <= '0;
            count <= CW'(N);
            if (bus.divisor_i == '0) begin
              state  <= DONE;
              quot_q <= '1;
              rem_q  <= bus.dividend_i;
              dbz_q  <= 1'b1;
            end else begin
              state <= CALC;
              dbz_q <= 1'b0;
            end
          end
        end
        CALC: begin
          q_sh  <= {q_sh[N-2:0], step[N]};
          r_reg <= step[N-1:0];
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state  <= DONE;
            quot_q <= {q_sh[N-2:0], step[N]};
            rem_q  <= step[N-1:0];
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Both handshake flags are pure decodes of the state register, so there is
  // no combinational path from in_valid to out_valid.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quot_o    = quot_q;
  assign bus.rem_o     = rem_q;
  assign bus.dbz_o     = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed and random checks of seq_div (N = 16).
module tb_seq_div;

  localparam int N = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  seq_div_if #(.N(N)) bus ();

  seq_div #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from a negedge, check latency and result, hold the
  // result for 'hold' cycles under backpressure, then consume it.
  // Returns at a negedge with the divider back in IDLE.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input bit poke,
                        input logic [15:0] eq, input logic [15:0] er, input logic ez,
                        input int elat, output logic [15:0] q, output logic [15:0] r);
    int   k;
    int   lat;
    logic z;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, " ready_before"}, {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid   = 1'b1;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.out_ready  = (hold == 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin
      bus.dividend_i = 16'($urandom);
      bus.divisor_i  = 16'($urandom);
      bus.in_valid   = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    q = bus.quot_o;
    r = bus.rem_o;
    z = bus.dbz_o;
    check({tag, " latency"}, lat, elat);
    check({tag, " quot"}, {16'b0, q}, {16'b0, eq});
    check({tag, " rem"}, {16'b0, r}, {16'b0, er});
    check({tag, " dbz"}, {31'b0, z}, {31'b0, ez});
    for (int j = 0; j < hold; j++) begin
      if (poke && j == 2) begin
        bus.in_valid   = 1'b1;
        bus.dividend_i = 16'd50;
        bus.divisor_i  = 16'd5;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({tag, " hold_valid"}, {31'b0, bus.out_valid}, 32'd1);
      check({tag, " hold_ready"}, {31'b0, bus.in_ready}, 32'd0);
      check({tag, " hold_quot"}, {16'b0, bus.quot_o}, {16'b0, eq});
      check({tag, " hold_rem"}, {16'b0, bus.rem_o}, {16'b0, er});
      check({tag, " hold_dbz"}, {31'b0, bus.dbz_o}, {31'b0, ez});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, " valid_drop"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, " ready_after"}, {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] q;
    logic [15:0] r;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] recon;
    int          seen;

    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;

    repeat (2) @(negedge clk);
    check("rst in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst quot", {16'b0, bus.quot_o}, 32'd0);
    check("rst rem", {16'b0, bus.rem_o}, 32'd0);
    check("rst dbz", {31'b0, bus.dbz_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("basic 100/7", 16'd100, 16'd7, 0, 1'b0, 16'd14, 16'd2, 1'b0, 16, q, r);
    run_op("ffff/1", 16'hFFFF, 16'd1, 0, 1'b0, 16'hFFFF, 16'd0, 1'b0, 16, q, r);
    run_op("ffff/ffff", 16'hFFFF, 16'hFFFF, 0, 1'b0, 16'd1, 16'd0, 1'b0, 16, q, r);
    run_op("3/10", 16'd3, 16'd10, 0, 1'b0, 16'd0, 16'd3, 1'b0, 16, q, r);
    run_op("8000/3", 16'h8000, 16'd3, 0, 1'b0, 16'h2AAA, 16'd2, 1'b0, 16, q, r);
    run_op("dbz 5/0", 16'd5, 16'd0, 0, 1'b0, 16'hFFFF, 16'd5, 1'b1, 0, q, r);
    run_op("after dbz 9/3", 16'd9, 16'd3, 0, 1'b0, 16'd3, 16'd0, 1'b0, 16, q, r);
    run_op("bp 100/7", 16'd100, 16'd7, 6, 1'b1, 16'd14, 16'd2, 1'b0, 16, q, r);
    run_op("bp then 50/5", 16'd50, 16'd5, 0, 1'b0, 16'd10, 16'd0, 1'b0, 16, q, r);

    // Asynchronous reset eight edges into 1000/9.
    bus.in_valid   = 1'b1;
    bus.dividend_i = 16'd1000;
    bus.divisor_i  = 16'd9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst quot", {16'b0, bus.quot_o}, 32'd0);
    check("midrst rem", {16'b0, bus.rem_o}, 32'd0);
    check("midrst dbz", {31'b0, bus.dbz_o}, 32'd0);
    check("midrst in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    bus.out_ready = 1'b0;
    check("midrst no_result", seen, 0);
    run_op("post rst 1000/9", 16'd1000, 16'd9, 0, 1'b0, 16'd111, 16'd1, 1'b0, 16, q, r);

    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 19) == 0) b = 16'd0;
      if (b == 16'd0) begin
        run_op("rand dbz", a, b, $urandom_range(0, 2), 1'b0, 16'hFFFF, a, 1'b1, 0, q, r);
      end else begin
        run_op("rand", a, b, $urandom_range(0, 2), 1'b0, a / b, a % b, 1'b0, 16, q, r);
        recon = {16'b0, q} * {16'b0, b} + {16'b0, r};
        check("rand recon", recon, {16'b0, a});
        check("rand rem_lt_div", {31'b0, (r < b)}, 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
